// File: rtl/dm_cache_ctrl_pkg.sv
// Shared parameters and types for the direct-mapped cache controller.
// Holds the memory-subsystem geometry (tag/index/offset widths), the
// controller state encoding and small address-slicing helpers.
package dm_cache_ctrl_pkg;

    localparam int TAG_LENGTH      = 8;
    localparam int INDEX_LENGTH    = 4;
    localparam int OFFSET_LENGTH   = 4;
    localparam int NUM_CACHE_LINES = 1 << INDEX_LENGTH;
    localparam int ADDR_LENGTH     = TAG_LENGTH + INDEX_LENGTH + OFFSET_LENGTH;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WRITE,
        RESP
    } ctrl_state_t;

    // Byte address layout is {tag, index, offset}.
    function automatic logic [INDEX_LENGTH-1:0] addr_index(input logic [ADDR_LENGTH-1:0] addr);
        return addr[OFFSET_LENGTH +: INDEX_LENGTH];
    endfunction

    function automatic logic [TAG_LENGTH-1:0] addr_tag(input logic [ADDR_LENGTH-1:0] addr);
        return addr[OFFSET_LENGTH + INDEX_LENGTH +: TAG_LENGTH];
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU request/response and main-memory handshake bundle of the cache
// controller.
//   slave  : the controller view (takes CPU requests, issues memory requests)
//   master : the environment view (CPU plus main memory)
// Signals:
//   cpu_req_valid/ready/we/addr   CPU request handshake
//   cpu_resp_valid/hit/err        one-cycle response pulse and status
//   mem_req/we/addr, mem_ack      main-memory request held until the ack pulse
interface dm_cache_ctrl_if
    import dm_cache_ctrl_pkg::*;
();
    logic                   cpu_req_valid;
    logic                   cpu_req_ready;
    logic                   cpu_req_we;
    logic [ADDR_LENGTH-1:0] cpu_req_addr;
    logic                   cpu_resp_valid;
    logic                   cpu_resp_hit;
    logic                   cpu_resp_err;
    logic                   mem_req;
    logic                   mem_we;
    logic [ADDR_LENGTH-1:0] mem_addr;
    logic                   mem_ack;

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, mem_ack,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_hit, cpu_resp_err,
               mem_req, mem_we, mem_addr
    );

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, mem_ack,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_hit, cpu_resp_err,
               mem_req, mem_we, mem_addr
    );

endinterface

// File: rtl/dm_cache_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
// Ports:
//   clk     clock, rising edge
//   resetn  asynchronous reset, active-high, clears the count
//   inc     increment request
//   count   current count value
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache controller. Decides hit/miss for each CPU request
// using the external tag memory, refills lines on read misses, writes
// through to main memory (no write-allocate), and owns the per-line valid
// bits plus the data-array write strobe.
// Ports:
//   clk, resetn          clock and asynchronous active-high reset
//   bus (slave)          CPU request/response and main-memory handshake
//   flush                invalidate all lines (deferred to IDLE if busy)
//   tm_write/index/tag_in, tm_tag_out   tag memory (read data one cycle late)
//   da_index, da_we      data-array index (mirrors tm_index) and write strobe
//   hit_count, miss_count  saturating statistics counters
module dm_cache_ctrl
    import dm_cache_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    dm_cache_ctrl_if.slave          bus,
    input  logic                    flush,
    output logic                    tm_write,
    output logic [INDEX_LENGTH-1:0] tm_index,
    output logic [TAG_LENGTH-1:0]   tm_tag_in,
    input  logic [TAG_LENGTH-1:0]   tm_tag_out,
    output logic [INDEX_LENGTH-1:0] da_index,
    output logic                    da_we,
    output logic [CNT_WIDTH-1:0]    hit_count,
    output logic [CNT_WIDTH-1:0]    miss_count
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    ctrl_state_t                state_reg, state_next;
    logic [ADDR_LENGTH-1:0]     addr_reg, addr_next;
    logic                       we_reg, we_next;
    logic                       hit_reg, hit_next;
    logic                       flush_pend_reg, flush_pend_next;
    logic [WAIT_W-1:0]          wait_reg, wait_next;
    logic [NUM_CACHE_LINES-1:0] valid_reg;

    logic                       valid_clr_all;
    logic                       valid_set;
    logic                       hit_inc;
    logic                       miss_inc;
    logic                       lookup_hit;
    logic [INDEX_LENGTH-1:0]    req_index;
    logic [INDEX_LENGTH-1:0]    cur_index;
    logic [TAG_LENGTH-1:0]      cur_tag;

    logic                       req_ready;
    logic                       resp_valid;
    logic                       resp_hit;
    logic                       resp_err;
    logic                       mreq;
    logic                       mwe;
    logic [ADDR_LENGTH-1:0]     maddr;

    assign req_index  = addr_index(bus.cpu_req_addr);
    assign cur_index  = addr_index(addr_reg);
    assign cur_tag    = addr_tag(addr_reg);
    // tm_tag_out belongs to the index presented during the accepting cycle,
    // so it is only meaningful in LOOKUP.
    assign lookup_hit = valid_reg[cur_index] && (tm_tag_out == cur_tag);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            hit_reg        <= 1'b0;
            flush_pend_reg <= 1'b0;
            wait_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            we_reg         <= we_next;
            hit_reg        <= hit_next;
            flush_pend_reg <= flush_pend_next;
            wait_reg       <= wait_next;
        end
    end

    // One flop per line so clear-all and single-line set stay independent.
    for (genvar gi = 0; gi < NUM_CACHE_LINES; gi++) begin : g_valid
        always_ff @(posedge clk or posedge resetn) begin
            if (resetn) begin
                valid_reg[gi] <= 1'b0;
            end else if (valid_clr_all) begin
                valid_reg[gi] <= 1'b0;
            end else if (valid_set && (cur_index == INDEX_LENGTH'(gi))) begin
                valid_reg[gi] <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        we_next         = we_reg;
        hit_next        = hit_reg;
        // A flush seen while busy is remembered until the next IDLE.
        flush_pend_next = flush_pend_reg | flush;
        wait_next       = wait_reg;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_hit        = 1'b0;
        resp_err        = 1'b0;
        mreq            = 1'b0;
        mwe             = 1'b0;
        maddr           = '0;
        tm_write        = 1'b0;
        tm_tag_in       = '0;
        tm_index        = cur_index;
        da_we           = 1'b0;
        valid_clr_all   = 1'b0;
        valid_set       = 1'b0;
        hit_inc         = 1'b0;
        miss_inc        = 1'b0;

        case (state_reg)
            IDLE: begin
                tm_index = req_index;
                if (flush || flush_pend_reg) begin
                    // Flush cycle: invalidate everything, accept nothing.
                    valid_clr_all   = 1'b1;
                    flush_pend_next = 1'b0;
                end else begin
                    req_ready = 1'b1;
                    if (bus.cpu_req_valid) begin
                        addr_next  = bus.cpu_req_addr;
                        we_next    = bus.cpu_req_we;
                        state_next = LOOKUP;
                    end
                end
            end

            LOOKUP: begin
                hit_next  = lookup_hit;
                hit_inc   = lookup_hit;
                miss_inc  = !lookup_hit;
                wait_next = '0;
                if (we_reg) begin
                    state_next = WRITE;
                end else if (lookup_hit) begin
                    resp_valid = 1'b1;
                    resp_hit   = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = REFILL;
                end
            end

            REFILL, WRITE: begin
                mwe   = (state_reg == WRITE);
                maddr = (state_reg == WRITE) ? addr_reg
                                             : {cur_tag, cur_index, {OFFSET_LENGTH{1'b0}}};
                // An ack in the timeout cycle still counts as completion.
                if (bus.mem_ack) begin
                    mreq       = 1'b1;
                    state_next = RESP;
                    if (state_reg == REFILL) begin
                        tm_write  = 1'b1;
                        tm_tag_in = cur_tag;
                        da_we     = 1'b1;
                        valid_set = 1'b1;
                    end else begin
                        da_we = hit_reg;
                    end
                end else if (wait_reg == WAIT_LIMIT) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    state_next = IDLE;
                end else begin
                    mreq      = 1'b1;
                    wait_next = wait_reg + 1'b1;
                end
            end

            RESP: begin
                resp_valid = 1'b1;
                resp_hit   = hit_reg;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign da_index           = tm_index;
    assign bus.cpu_req_ready  = req_ready;
    assign bus.cpu_resp_valid = resp_valid;
    assign bus.cpu_resp_hit   = resp_hit;
    assign bus.cpu_resp_err   = resp_err;
    assign bus.mem_req        = mreq;
    assign bus.mem_we         = mwe;
    assign bus.mem_addr       = maddr;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (hit_inc),
        .count  (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (miss_inc),
        .count  (miss_count)
    );

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: a tag-memory model plus a scripted main-memory
// responder. Table-driven transactions followed by hand-written flush and
// mid-operation reset sequences. A 3-bit counter width exercises saturation.
module tb_dm_cache_ctrl;
    import dm_cache_ctrl_pkg::*;

    localparam int TB_TIMEOUT = 8;
    localparam int TB_CNT_W   = 3;

    logic                    clk;
    logic                    resetn;
    logic                    flush;
    logic                    tm_write;
    logic [INDEX_LENGTH-1:0] tm_index;
    logic [TAG_LENGTH-1:0]   tm_tag_in;
    logic [TAG_LENGTH-1:0]   tm_tag_out;
    logic [INDEX_LENGTH-1:0] da_index;
    logic                    da_we;
    logic [TB_CNT_W-1:0]     hit_count;
    logic [TB_CNT_W-1:0]     miss_count;

    dm_cache_ctrl_if bus();

    dm_cache_ctrl #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .CNT_WIDTH   (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus.slave),
        .flush      (flush),
        .tm_write   (tm_write),
        .tm_index   (tm_index),
        .tm_tag_in  (tm_tag_in),
        .tm_tag_out (tm_tag_out),
        .da_index   (da_index),
        .da_we      (da_we),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag memory model: registered read, write on tm_write.
    logic [TAG_LENGTH-1:0] tag_array [NUM_CACHE_LINES];
    always @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < NUM_CACHE_LINES; i++) tag_array[i] <= '0;
            tm_tag_out <= '0;
        end else begin
            if (tm_write) tag_array[tm_index] <= tm_tag_in;
            tm_tag_out <= tag_array[tm_index];
        end
    end

    typedef struct {
        logic                   we;
        logic [ADDR_LENGTH-1:0] addr;
        int                     ack_delay;   // cycles after first mem_req; -1 = never
        int                     flush_idx;   // wait cycle to pulse flush; -1 = never
        logic                   exp_hit;
        logic                   exp_err;
        int                     exp_lat;     // accept cycle counts as 1
        int                     exp_req_cycles;
        logic [ADDR_LENGTH-1:0] exp_mem_addr;
        int                     exp_tm_wr;
        logic [TAG_LENGTH-1:0]  exp_tag;
        int                     exp_da_we;
        int                     exp_hits;
        int                     exp_misses;
    } vec_t;

    typedef struct {
        logic                    got_resp;
        logic                    hit;
        logic                    err;
        int                      lat;
        int                      req_cycles;
        logic                    mem_we;
        logic [ADDR_LENGTH-1:0]  mem_addr;
        int                      tm_wr;
        logic [TAG_LENGTH-1:0]   tm_tag;
        logic [INDEX_LENGTH-1:0] tm_idx;
        int                      da_we;
        int                      idx_bad;
    } obs_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input logic we, input logic [ADDR_LENGTH-1:0] addr,
                          input int ack_delay, input int flush_idx, output obs_t o);
        int  waitn;
        int  idx;
        bit  seen;
        o = '{default: 0};
        @(negedge clk);
        waitn = 0;
        while (!bus.cpu_req_ready && waitn < 20) begin
            @(negedge clk);
            waitn++;
        end
        if (!bus.cpu_req_ready) return;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = we;
        bus.cpu_req_addr  = addr;
        @(posedge clk);
        seen = 0;
        idx  = 0;
        for (int c = 2; c < 80 && !o.got_resp; c++) begin
            @(negedge clk);
            bus.cpu_req_valid = 1'b0;
            bus.mem_ack       = 1'b0;
            flush             = 1'b0;
            #1;
            if (seen) idx++;
            else if (bus.mem_req) seen = 1;
            if (seen && idx == ack_delay) bus.mem_ack = 1'b1;
            if (seen && idx == flush_idx) flush = 1'b1;
            #1;
            if (bus.mem_req) begin
                o.req_cycles++;
                o.mem_we   = bus.mem_we;
                o.mem_addr = bus.mem_addr;
            end
            if (tm_write) begin
                o.tm_wr++;
                o.tm_tag = tm_tag_in;
                o.tm_idx = tm_index;
            end
            if (da_we) o.da_we++;
            if (da_index !== tm_index) o.idx_bad++;
            if (bus.cpu_resp_valid) begin
                o.got_resp = 1'b1;
                o.hit      = bus.cpu_resp_hit;
                o.err      = bus.cpu_resp_err;
                o.lat      = c;
            end
        end
    endtask

    // Runs one transaction, checks it, then checks counters in the next cycle.
    task automatic run_vec(input string tag, input vec_t v);
        obs_t o;
        do_txn(v.we, v.addr, v.ack_delay, v.flush_idx, o);
        $display("txn %s: we=%0b addr=%h ack_delay=%0d -> resp=%0b hit=%0b err=%0b lat=%0d req_cycles=%0d",
                 tag, v.we, v.addr, v.ack_delay, o.got_resp, o.hit, o.err, o.lat, o.req_cycles);
        check({tag, ".resp_seen"}, o.got_resp, 1);
        check({tag, ".hit"}, o.hit, v.exp_hit);
        check({tag, ".err"}, o.err, v.exp_err);
        check({tag, ".latency"}, o.lat, v.exp_lat);
        check({tag, ".mem_req_cycles"}, o.req_cycles, v.exp_req_cycles);
        if (v.exp_req_cycles > 0) begin
            check({tag, ".mem_we"}, o.mem_we, v.we);
            check({tag, ".mem_addr"}, o.mem_addr, v.exp_mem_addr);
        end
        check({tag, ".tm_write_cycles"}, o.tm_wr, v.exp_tm_wr);
        if (v.exp_tm_wr > 0) begin
            check({tag, ".tm_tag_in"}, o.tm_tag, v.exp_tag);
            check({tag, ".tm_index"}, o.tm_idx, addr_index(v.addr));
        end
        check({tag, ".da_we_cycles"}, o.da_we, v.exp_da_we);
        check({tag, ".da_index_mismatch"}, o.idx_bad, 0);
        @(negedge clk);
        #1;
        check({tag, ".hit_count"}, hit_count, v.exp_hits);
        check({tag, ".miss_count"}, miss_count, v.exp_misses);
    endtask

    // A = tag 12 idx 3, B = tag 34 idx 3, C = tag 56 idx 7, D = tag 00 idx 9.
    // Miss counter is 3 bits wide and saturates at 7.
    vec_t vecs [10];
    vec_t v_manual;
    int   resp_pulses;
    int   req_after_rst;

    initial begin
        //        we  addr     ack flsh hit err lat req mem_addr tmwr tag    da  hits miss
        vecs = '{
            '{1'b0, 16'h1235,  4, -1, 1'b0, 1'b0,  8, 5, 16'h1230, 1, 8'h12, 1, 0, 1},
            '{1'b0, 16'h1235, -1, -1, 1'b1, 1'b0,  2, 0, 16'h0000, 0, 8'h00, 0, 1, 1},
            '{1'b0, 16'h343A,  2, -1, 1'b0, 1'b0,  6, 3, 16'h3430, 1, 8'h34, 1, 1, 2},
            '{1'b0, 16'h1235,  1, -1, 1'b0, 1'b0,  5, 2, 16'h1230, 1, 8'h12, 1, 1, 3},
            '{1'b1, 16'h1235,  2, -1, 1'b1, 1'b0,  6, 3, 16'h1235, 0, 8'h00, 1, 2, 3},
            '{1'b1, 16'h5672,  0, -1, 1'b0, 1'b0,  4, 1, 16'h5672, 0, 8'h00, 0, 2, 4},
            '{1'b0, 16'h0094, -1, -1, 1'b0, 1'b1, 11, 8, 16'h0090, 0, 8'h00, 0, 2, 5},
            '{1'b0, 16'h0094,  3, -1, 1'b0, 1'b0,  7, 4, 16'h0090, 1, 8'h00, 1, 2, 6},
            '{1'b0, 16'h0094, -1, -1, 1'b1, 1'b0,  2, 0, 16'h0000, 0, 8'h00, 0, 3, 6},
            '{1'b0, 16'h343A,  8, -1, 1'b0, 1'b0, 12, 9, 16'h3430, 1, 8'h34, 1, 3, 7}
        };

        resetn            = 1'b1;
        flush             = 1'b0;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_addr  = '0;
        bus.mem_ack       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset.cpu_req_ready", bus.cpu_req_ready, 1);
        check("reset.cpu_resp_valid", bus.cpu_resp_valid, 0);
        check("reset.mem_req", bus.mem_req, 0);
        check("reset.mem_addr", bus.mem_addr, 0);
        check("reset.tm_write", tm_write, 0);
        check("reset.tm_tag_in", tm_tag_in, 0);
        check("reset.da_we", da_we, 0);
        check("reset.hit_count", hit_count, 0);
        check("reset.miss_count", miss_count, 0);
        resetn = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Flush during a refill of A: refill still completes, then the first
        // IDLE cycle is spent invalidating, so A misses again afterwards.
        v_manual = '{1'b0, 16'h1235, 4, 1, 1'b0, 1'b0, 8, 5, 16'h1230, 1, 8'h12, 1, 3, 7};
        run_vec("flush_refill", v_manual);
        check("flush_idle.cpu_req_ready", bus.cpu_req_ready, 0);
        v_manual = '{1'b0, 16'h1235, 1, -1, 1'b0, 1'b0, 5, 2, 16'h1230, 1, 8'h12, 1, 3, 7};
        run_vec("after_flush", v_manual);

        // Reset while REFILL is waiting for memory.
        @(negedge clk);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_addr  = 16'h5672;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("midrst.mem_req_before", bus.mem_req, 1);
        resetn = 1'b1;
        #1;
        check("midrst.mem_req", bus.mem_req, 0);
        check("midrst.cpu_req_ready", bus.cpu_req_ready, 1);
        check("midrst.miss_count", miss_count, 0);
        resp_pulses   = 0;
        req_after_rst = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            if (bus.cpu_resp_valid) resp_pulses++;
        end
        resetn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (bus.cpu_resp_valid) resp_pulses++;
            if (bus.mem_req) req_after_rst++;
        end
        $display("txn midrst: resp_pulses=%0d mem_req_cycles=%0d", resp_pulses, req_after_rst);
        check("midrst.resp_pulses", resp_pulses, 0);
        check("midrst.mem_req_after", req_after_rst, 0);
        v_manual = '{1'b0, 16'h1235, 1, -1, 1'b0, 1'b0, 5, 2, 16'h1230, 1, 8'h12, 1, 0, 1};
        run_vec("after_rst", v_manual);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped cache controller. Sits directly downstream of tag_mem: it drives tag_mem's write/index/tag_in and consumes tag_out.
- Decides hit or miss per CPU request. Sequences line refills and write-throughs to main memory over a req/ack handshake.
- Owns the per-line valid bits and the data-array write strobe.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles to wait for mem_ack before aborting with an error.
- CNT_WIDTH, 32: width of the saturating hit and miss counters.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous reset, active-high (resetn=1 holds the block in reset).
- cpu_req_valid  in  1  CPU request valid.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_req_we  in  1  1=write, 0=read.
- cpu_req_addr  in  ADDR_LENGTH  byte address {tag,index,offset}.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_resp_hit  out  1  request hit (valid with cpu_resp_valid).
- cpu_resp_err  out  1  memory timeout (valid with cpu_resp_valid).
- flush  in  1  invalidate all lines.
- tm_write  out  1  tag_mem write enable.
- tm_index  out  INDEX_LENGTH  tag_mem index.
- tm_tag_in  out  TAG_LENGTH  tag_mem write data.
- tm_tag_out  in  TAG_LENGTH  tag_mem read data; valid one cycle after tm_index.
- da_index  out  INDEX_LENGTH  data-array index (equals tm_index).
- da_we  out  1  data-array write strobe.
- mem_req  out  1  main-memory request.
- mem_we  out  1  1=write-through, 0=line refill.
- mem_addr  out  ADDR_LENGTH  line-aligned for refill; full address for write.
- mem_ack  in  1  memory done (single-cycle pulse).
- hit_count  out  CNT_WIDTH  saturating hit counter.
- miss_count  out  CNT_WIDTH  saturating miss counter.

Behaviour:
- Reset values:
  - State = IDLE; all valid bits = 0; counters = 0.
  - All outputs are 0 except cpu_req_ready = 1.
- Reset mid-operation: abandons any transaction immediately. No response is issued; mem_req drops the same cycle.
- IDLE:
  - cpu_req_ready = 1.
  - On cpu_req_valid: latch addr and we; drive tm_index = index; go to LOOKUP. cpu_req_ready drops the next cycle.
  - If flush is pending or asserted: clear all valid bits this cycle and accept no request. The request is accepted the following cycle.
- LOOKUP: hit = valid[index] && (tm_tag_out == tag).
  - Read hit: cpu_resp_valid = 1, hit = 1; increment hit_count; go to IDLE. Latency is 2 cycles from acceptance.
  - Read miss: increment miss_count; go to REFILL.
  - Write (hit or miss): count as hit or miss; go to WRITE. Writes are no-write-allocate.
- REFILL:
  - Hold mem_req = 1, mem_we = 0, mem_addr = {tag, index, 0}.
  - On mem_ack: tm_write = 1, tm_tag_in = tag, da_we = 1, set valid[index] (all the same cycle); go to RESP.
- WRITE:
  - Hold mem_req = 1, mem_we = 1, mem_addr = latched address.
  - On mem_ack: da_we = 1 only if the lookup hit; go to RESP.
- RESP: cpu_resp_valid = 1; cpu_resp_hit = lookup result; cpu_resp_err = 0; go to IDLE.
- Timeout:
  - A wait counter clears on entry to REFILL or WRITE and increments each cycle without mem_ack.
  - When it reaches MEM_TIMEOUT: drop mem_req; issue cpu_resp_valid with err = 1; make no tag, valid or data update; go to IDLE.
  - mem_ack in the same cycle as timeout wins (normal completion).
- flush outside IDLE: latched as pending and applied at the next IDLE. The in-flight refill still completes, then its line is invalidated by the flush.
- Counters saturate at all-ones (no wrap).
- da_index always equals tm_index (the latched index outside IDLE).

Decomposition:
- memory_sub_system_param gains:
  - OFFSET_LENGTH;
  - ADDR_LENGTH = TAG_LENGTH + INDEX_LENGTH + OFFSET_LENGTH;
  - enum ctrl_state_t {IDLE, LOOKUP, REFILL, WRITE, RESP}.
- Existing TAG_LENGTH, INDEX_LENGTH and NUM_CACHE_LINES are reused.
- One sub-module, sat_counter (parameterised width, inc, saturating), instantiated twice.

Test Plan:
- Cold read addr A (index 3, tag 0x12), mem_ack 4 cycles after mem_req:
  - mem_req with mem_addr line-aligned;
  - then tm_write = 1, tag_in = 0x12, da_we = 1;
  - resp hit = 0; miss_count = 1.
- Re-read A: resp 2 cycles after accept, hit = 1, no mem_req; hit_count = 1.
- Read B (same index 3, tag 0x34): miss; refill overwrites the tag; re-read A then misses again.
- Write to A after a refill of A: mem_we = 1, da_we = 1 on ack, resp hit = 1. Write to an uncached C: mem_req issued, da_we stays 0, resp hit = 0.
- Read miss with mem_ack withheld, MEM_TIMEOUT = 8: after 8 cycles mem_req drops, resp err = 1, valid[index] stays 0.
- flush asserted during REFILL: refill completes and responds; in the next IDLE all valid bits clear, and re-reading A misses.
- Assert resetn mid-REFILL: mem_req = 0 and cpu_req_ready = 1 immediately, and no response pulse is seen.
